// File: rtl/imem_port_arbiter_if.sv
// Bundle of all fetch, loader and memory-side signals of the instruction
// memory port arbiter. The slave modport is the arbiter's view; the master
// modport is the view of the surrounding fetch unit, loader and memory.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  // Fetch side
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_kill;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;
  // Loader side
  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata;
  logic              l_gnt;
  logic              l_done;
  logic [31:0]       l_rdata;
  // Memory side
  logic              m_cs_n;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;
  // Status
  logic              busy;
  logic              dbg_state;

  modport slave (
    input  f_req, f_addr, f_kill, l_req, l_we, l_addr, l_wdata, m_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_done, l_rdata,
    output m_cs_n, m_we, m_addr, m_wdata, busy, dbg_state
  );

  modport master (
    output f_req, f_addr, f_kill, l_req, l_we, l_addr, l_wdata, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_done, l_rdata,
    input  m_cs_n, m_we, m_addr, m_wdata, busy, dbg_state
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one instruction-memory port between the fetch stage and the
// loader/debug port. Each access holds chip select low for MEM_LAT cycles,
// then the read data is returned to the owner with a one-cycle pulse.
//
// Handshake: req is a level held (with its address/data) until gnt is seen
// high in the same cycle; gnt is combinational and the request is consumed at
// the rising edge that ends that cycle. f_rvalid / l_done are single-cycle
// pulses with no back-pressure; the requester must take the data that cycle.
module imem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic                  clk,
  input logic                  rst,
  imem_port_arbiter_if.slave   bus
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic FETCH  = 1'b0;
  localparam logic LOADER = 1'b1;

  state_e          state;
  state_e          state_nxt;
  logic [CW-1:0]   count;
  logic            owner;
  logic            last_winner;
  logic            drop;

  logic            f_win;
  logic            l_win;
  logic            f_gnt_i;
  logic            l_gnt_i;
  logic            last_cycle;

  logic              m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [31:0]       m_wdata_q;
  logic [31:0]       f_rdata_q;
  logic [31:0]       l_rdata_q;
  logic              f_rvalid_q;
  logic              l_done_q;

  // Round-robin: a sole requester wins; on contention the one that did not
  // win last time goes first.
  assign f_win = bus.f_req & (~bus.l_req | (last_winner == LOADER));
  assign l_win = bus.l_req & (~bus.f_req | (last_winner == FETCH));

  assign last_cycle = (state == ACCESS) && (count == CW'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: leave IDLE on any grant, return after the last access cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (f_win || l_win) state_nxt = ACCESS;
      ACCESS:  if (count == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state: grants only in IDLE, chip select during ACCESS
  always_comb begin
    f_gnt_i    = 1'b0;
    l_gnt_i    = 1'b0;
    bus.m_cs_n = 1'b1;
    bus.busy   = 1'b0;
    if (state == IDLE) begin
      f_gnt_i = f_win;
      l_gnt_i = l_win;
    end else begin
      bus.m_cs_n = 1'b0;
      bus.busy   = 1'b1;
    end
  end

  // Access datapath: latch the winner's request, count the latency down and
  // capture the read data on the final access cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      owner       <= FETCH;
      last_winner <= LOADER;
      drop        <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      f_rdata_q   <= '0;
      l_rdata_q   <= '0;
      f_rvalid_q  <= 1'b0;
      l_done_q    <= 1'b0;
    end else begin
      f_rvalid_q <= 1'b0;
      l_done_q   <= 1'b0;
      if (state == IDLE) begin
        if (f_gnt_i) begin
          m_addr_q    <= {bus.f_addr[ADDR_W-1:2], 2'b00};
          m_we_q      <= 1'b0;
          owner       <= FETCH;
          last_winner <= FETCH;
          count       <= CW'(MEM_LAT);
          // A redirect in the grant cycle kills the fetch before it starts.
          drop        <= bus.f_kill;
        end else if (l_gnt_i) begin
          m_addr_q    <= {bus.l_addr[ADDR_W-1:2], 2'b00};
          m_we_q      <= bus.l_we;
          m_wdata_q   <= bus.l_wdata;
          owner       <= LOADER;
          last_winner <= LOADER;
          count       <= CW'(MEM_LAT);
          drop        <= 1'b0;
        end
      end else begin
        count <= count - CW'(1);
        if (owner == FETCH && bus.f_kill) drop <= 1'b1;
        if (last_cycle) begin
          m_we_q <= 1'b0;
          drop   <= 1'b0;
          if (owner == FETCH) begin
            // A kill arriving in the final cycle still discards the word.
            if (!drop && !bus.f_kill) begin
              f_rdata_q  <= bus.m_rdata;
              f_rvalid_q <= 1'b1;
            end
          end else begin
            l_done_q <= 1'b1;
            if (!m_we_q) l_rdata_q <= bus.m_rdata;
          end
        end
      end
    end
  end

  assign bus.f_gnt     = f_gnt_i;
  assign bus.l_gnt     = l_gnt_i;
  assign bus.m_we      = m_we_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.l_rdata   = l_rdata_q;
  assign bus.f_rvalid  = f_rvalid_q;
  assign bus.l_done    = l_done_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with MEM_LAT=2 and a 64-word memory
// model preloaded with 0xA000_0000 | word_index.
module tb_imem_port_arbiter;

  localparam int ADDR_W = 32;

  logic clk;
  logic rst;

  imem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  imem_port_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory model: combinational read, write on the rising edge while selected
  logic [31:0] mem [0:63];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    forever begin
      @(posedge clk);
      if (!bus.m_cs_n && bus.m_we) mem[bus.m_addr[7:2]] <= bus.m_wdata;
    end
  end

  assign bus.m_rdata = mem[bus.m_addr[7:2]];

  // Checking
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every fetch response must match the oldest expected word
  always @(negedge clk) begin
    if (!rst && bus.f_rvalid) begin
      if (exp_q.size() == 0) check("unexpected_f_rvalid", 32'd1, 32'd0);
      else                   check("sb_f_rdata", bus.f_rdata, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.f_kill  = 1'b0;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_addr  = '0;
    bus.l_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_m_cs_n", bus.m_cs_n, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_m_we", bus.m_we, 0);
    check("rst_m_addr", bus.m_addr, 0);
    check("rst_f_rdata", bus.f_rdata, 0);
    check("rst_l_rdata", bus.l_rdata, 0);
    check("rst_f_rvalid", bus.f_rvalid, 0);
    check("rst_l_done", bus.l_done, 0);

    // Single fetch of 0x10
    next_cycle();
    bus.f_req = 1'b1; bus.f_addr = 32'h10;
    @(negedge clk);
    check("t1_f_gnt", bus.f_gnt, 1);
    check("t1_l_gnt", bus.l_gnt, 0);
    exp_q.push_back(32'hA000_0004);
    next_cycle();
    bus.f_req = 1'b0;
    @(negedge clk);
    check("t1_c2_cs_n", bus.m_cs_n, 0);
    check("t1_c2_addr", bus.m_addr, 32'h10);
    check("t1_c2_busy", bus.busy, 1);
    next_cycle();
    @(negedge clk);
    check("t1_c3_cs_n", bus.m_cs_n, 0);
    check("t1_c3_rvalid", bus.f_rvalid, 0);
    next_cycle();
    @(negedge clk);
    check("t1_c4_rvalid", bus.f_rvalid, 1);
    check("t1_c4_rdata", bus.f_rdata, 32'hA000_0004);
    check("t1_c4_cs_n", bus.m_cs_n, 1);
    next_cycle();
    @(negedge clk);
    check("t1_c5_rvalid", bus.f_rvalid, 0);

    // Contention from reset: fetch, loader, fetch in cycles 1, 4, 7
    do_reset();
    next_cycle();
    bus.f_req = 1'b1; bus.f_addr = 32'h04;
    bus.l_req = 1'b1; bus.l_addr = 32'h08; bus.l_we = 1'b0;
    for (int g = 0; g < 3; g++) begin
      if (g > 0) next_cycle();
      @(negedge clk);
      check("rr_f_gnt", bus.f_gnt, (g % 2 == 0));
      check("rr_l_gnt", bus.l_gnt, (g % 2 == 1));
      if (g % 2 == 0) exp_q.push_back(32'hA000_0001);
      if (g == 2) begin
        check("rr_l_done", bus.l_done, 1);
        check("rr_l_rdata", bus.l_rdata, 32'hA000_0002);
      end
      for (int k = 0; k < 2; k++) begin
        next_cycle();
        if (g == 2) begin
          bus.f_req = 1'b0;
          bus.l_req = 1'b0;
        end
        @(negedge clk);
        check("rr_no_gnt", {31'd0, bus.f_gnt | bus.l_gnt}, 0);
      end
    end
    next_cycle();
    next_cycle();

    // Loader write of 0x20, then fetch it back in the response cycle
    next_cycle();
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h20; bus.l_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wr_l_gnt", bus.l_gnt, 1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("wr_c2_m_we", bus.m_we, 1);
    check("wr_c2_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    check("wr_c2_cs_n", bus.m_cs_n, 0);
    next_cycle();
    @(negedge clk);
    check("wr_c3_m_we", bus.m_we, 1);
    next_cycle();
    bus.f_req = 1'b1; bus.f_addr = 32'h20;
    @(negedge clk);
    check("wr_l_done", bus.l_done, 1);
    check("wr_l_rdata_hold", bus.l_rdata, 32'hA000_0002);
    check("wr_c4_m_we", bus.m_we, 0);
    check("wr_fetch_gnt", bus.f_gnt, 1);
    exp_q.push_back(32'hDEAD_BEEF);
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rb_f_rvalid", bus.f_rvalid, 1);
    check("rb_f_rdata", bus.f_rdata, 32'hDEAD_BEEF);

    // Kill during access; a fetch granted in the would-be response cycle
    next_cycle();
    bus.f_req = 1'b1; bus.f_addr = 32'h30;
    @(negedge clk);
    check("kl_f_gnt", bus.f_gnt, 1);
    next_cycle();
    bus.f_req = 1'b0; bus.f_kill = 1'b1;
    next_cycle();
    bus.f_kill = 1'b0;
    next_cycle();
    bus.f_req = 1'b1; bus.f_addr = 32'h08;
    @(negedge clk);
    check("kl_no_rvalid", bus.f_rvalid, 0);
    check("kl_rdata_hold", bus.f_rdata, 32'hDEAD_BEEF);
    check("kl_regrant", bus.f_gnt, 1);
    exp_q.push_back(32'hA000_0002);
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("kl_next_rvalid", bus.f_rvalid, 1);

    // Misaligned loader read of 0x23
    next_cycle();
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h23;
    @(negedge clk);
    check("ma_l_gnt", bus.l_gnt, 1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("ma_m_addr", bus.m_addr, 32'h20);
    check("ma_m_we", bus.m_we, 0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("ma_l_done", bus.l_done, 1);
    check("ma_l_rdata", bus.l_rdata, 32'hDEAD_BEEF);

    // Kill together with request in IDLE: granted but dropped
    next_cycle();
    bus.f_req = 1'b1; bus.f_kill = 1'b1; bus.f_addr = 32'h00;
    @(negedge clk);
    check("kg_f_gnt", bus.f_gnt, 1);
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("kg_no_rvalid", bus.f_rvalid, 0);
    check("kg_rdata_hold", bus.f_rdata, 32'hA000_0002);

    // Async reset in cycle 2 of a fetch
    next_cycle();
    bus.f_req = 1'b1; bus.f_addr = 32'h14;
    @(negedge clk);
    check("ar_f_gnt", bus.f_gnt, 1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("ar_cs_n_before", bus.m_cs_n, 0);
    #1 rst = 1'b1;
    #1;
    check("ar_cs_n_now", bus.m_cs_n, 1);
    check("ar_busy_now", bus.busy, 0);
    check("ar_f_rdata_clr", bus.f_rdata, 0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      check("ar_no_rvalid", bus.f_rvalid, 0);
    end
    next_cycle();
    bus.f_req = 1'b1; bus.f_addr = 32'h14;
    bus.l_req = 1'b1; bus.l_addr = 32'h18;
    @(negedge clk);
    check("ar_rr_f_gnt", bus.f_gnt, 1);
    check("ar_rr_l_gnt", bus.l_gnt, 0);
    exp_q.push_back(32'hA000_0005);
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("ar_rr_rvalid", bus.f_rvalid, 1);
    next_cycle();
    next_cycle();

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single instruction-memory port between two requesters: the pipeline fetch stage (read-only) and the program loader/debug port (read/write).
- Sequences each access over a fixed memory latency and returns the read data to the requester that owns the access.
- Supports dropping an in-flight fetch on a pipeline redirect.
- Sits between the IF stage/loader and the instruction memory. Drives the memory's active-low chip select.

Parameters:
- ADDR_W, 32, address width for all address ports.
- MEM_LAT, 2, number of cycles m_cs_n is held low per access; legal values are ≥1.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- f_req  in  1  fetch request.
- f_addr  in  ADDR_W  fetch byte address.
- f_kill  in  1  pipeline redirect; discards an in-flight fetch.
- f_gnt  out  1  fetch request accepted this cycle (combinational).
- f_rvalid  out  1  one-cycle pulse: f_rdata valid.
- f_rdata  out  32  fetched instruction word.
- l_req  in  1  loader request.
- l_we  in  1  loader write enable (1 = write, 0 = read).
- l_addr  in  ADDR_W  loader byte address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader request accepted this cycle (combinational).
- l_done  out  1  one-cycle pulse: loader access complete (read or write).
- l_rdata  out  32  loader read data.
- m_cs_n  out  1  memory chip select, active-low.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory word address; bits [1:0] are forced to 0.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid during the last ACCESS cycle.
- busy  out  1  high while state = ACCESS.

Behaviour:
- Reset (async, any state):
  - state = IDLE; m_cs_n = 1.
  - m_we, m_addr, m_wdata, f_rdata, l_rdata, f_rvalid, l_done, busy = 0.
  - last_winner = LOADER; drop = 0; count = 0.
  - An access in flight at reset is abandoned; it produces no rvalid or done.
- FSM has two states, IDLE and ACCESS.
  - IDLE:
    - f_gnt/l_gnt go to at most one requester.
    - Sole requester wins.
    - Both requesting: round-robin; the requester that is not last_winner wins.
    - On grant at edge T:
      - latch address (bits [1:0] cleared), we (fetch always 0) and wdata into m_*;
      - set owner; update last_winner;
      - count = MEM_LAT; state → ACCESS.
  - ACCESS: m_cs_n = 0, busy = 1, no grants. count decrements every cycle.
  - When count = 1 at an edge, the access completes:
    - m_rdata is registered into f_rdata (fetch owner, not dropped) or l_rdata (loader read);
    - on the next cycle f_rvalid or l_done pulses for exactly one cycle;
    - m_cs_n = 1, m_we = 0; state → IDLE.
- Timing: grant in cycle T → m_cs_n low T+1 … T+MEM_LAT → response pulse in T+MEM_LAT+1.
- A new grant may occur in the same cycle as the response pulse. Peak throughput is one access per MEM_LAT+1 cycles.
- Loader write: l_done pulses; l_rdata holds its previous value.
- f_kill:
  - High in the fetch grant cycle or any ACCESS cycle of a fetch-owned access: sets drop.
  - At completion with drop set: f_rvalid stays 0, f_rdata holds its previous value, drop clears.
  - f_kill has no effect on loader accesses or in IDLE without a fetch grant.
- f_kill and f_req high together in IDLE: the request is still granted, but it is dropped immediately. The fetch unit re-requests after the redirect.
- Requests are level: a requester holds req/addr/data until it sees gnt. Changes in inputs after grant do not affect the access.
- Misaligned addresses are not flagged; the low two bits are silently cleared.
- rvalid/done and gnt are independent: no combinational path from m_rdata to gnt.

Test Plan:
- Reset then single fetch, MEM_LAT=2: f_req=1, f_addr=0x10 at cycle 1 → f_gnt=1 in cycle 1; m_cs_n=0, m_addr=0x10 in cycles 2–3; f_rvalid=1 with f_rdata=mem[0x10] in cycle 4.
- Contention from reset: f_req=l_req=1 held → fetch granted first; loader granted in cycle 4 (the response cycle); then fetch again in cycle 7. Grants alternate strictly.
- Loader write then fetch read back: l_we=1, l_addr=0x20, l_wdata=0xDEADBEEF → m_we=1 for 2 cycles, l_done pulse. Then fetch of 0x20 → f_rdata=0xDEADBEEF.
- Kill: fetch granted at cycle 1, f_kill=1 in cycle 2 → no f_rvalid in cycle 4 and f_rdata unchanged. A fetch granted in cycle 4 completes normally.
- Misaligned address: l_addr=0x23 read → m_addr=0x20; l_rdata=mem[0x20].
- Async reset mid-access: rst pulsed in cycle 2 of a fetch → m_cs_n=1, busy=0 immediately; no f_rvalid after release; first post-reset contention grants fetch.
